// File: rtl/bf_pair_merge.sv
// bf_pair_merge
// Merges the parallel sum (A+B) and difference (A-B) streams of a split
// butterfly back into one LANES-wide stream. Within each group of BLK input
// beats the sum lanes are forwarded at once and the difference lanes are
// buffered. Right after the last sum beat the buffered differences play out
// with no gap, so downstream sees BLK sum beats followed by BLK difference
// beats.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   din_valid            qualifies all din_* lanes this cycle
//   din_add_r/_i         sum stream, LANES x DATA_WIDTH signed lanes
//   din_sub_r/_i         difference stream, LANES x DATA_WIDTH signed lanes
//   dout_valid           output beat valid
//   dout_r/_i            merged stream, lanes passed through bit-exact
//   dout_sog             first beat of a group (first sum beat)
//   dout_eof             last beat of the last group of a frame
//   err_ovf              sticky: an input beat arrived while draining
//
// States
//   state   | meaning
//   COLLECT | forward sum beats, buffer difference beats
//   DRAIN   | play out BLK buffered difference beats back-to-back
module bf_pair_merge #(
   parameter int DATA_WIDTH = 12,
   parameter int LANES      = 16,
   parameter int BLK        = 2,
   parameter int GROUPS     = 16
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 din_valid,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     din_add_r,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     din_add_i,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     din_sub_r,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     din_sub_i,
   output logic                                 dout_valid,
   output logic [LANES-1:0][DATA_WIDTH-1:0]     dout_r,
   output logic [LANES-1:0][DATA_WIDTH-1:0]     dout_i,
   output logic                                 dout_sog,
   output logic                                 dout_eof,
   output logic                                 err_ovf
);

   localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;
   localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [CW-1:0] BLK_LAST = CW'(BLK - 1);
   localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

   typedef logic [LANES-1:0][DATA_WIDTH-1:0] beat_t;
   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wcnt, wcnt_nxt;
   logic [CW-1:0] rcnt, rcnt_nxt;
   logic [GW-1:0] gcnt, gcnt_nxt;

   logic  valid_nxt, sog_nxt, eof_nxt, ovf_nxt;
   beat_t r_nxt, i_nxt;
   logic  buf_we;

   // Difference buffer; contents are only ever read after being written in
   // the same group, so it carries no reset.
   beat_t sub_buf_r [BLK];
   beat_t sub_buf_i [BLK];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      rcnt_nxt  = rcnt;
      gcnt_nxt  = gcnt;
      valid_nxt = 1'b0;
      sog_nxt   = 1'b0;
      eof_nxt   = 1'b0;
      ovf_nxt   = err_ovf;
      r_nxt     = dout_r;
      i_nxt     = dout_i;
      buf_we    = 1'b0;
      case (state)
         COLLECT: begin
            if (din_valid) begin
               r_nxt     = din_add_r;
               i_nxt     = din_add_i;
               valid_nxt = 1'b1;
               sog_nxt   = (wcnt == '0);
               buf_we    = 1'b1;
               if (wcnt == BLK_LAST) begin
                  wcnt_nxt  = '0;
                  rcnt_nxt  = '0;
                  state_nxt = DRAIN;
               end else begin
                  wcnt_nxt = wcnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            // An input beat here breaks the upstream contract: flag it and
            // drop it without touching the buffer or the write count.
            if (din_valid) begin
               ovf_nxt = 1'b1;
            end
            r_nxt     = sub_buf_r[rcnt];
            i_nxt     = sub_buf_i[rcnt];
            valid_nxt = 1'b1;
            if (rcnt == BLK_LAST) begin
               state_nxt = COLLECT;
               rcnt_nxt  = '0;
               eof_nxt   = (gcnt == GRP_LAST);
               gcnt_nxt  = (gcnt == GRP_LAST) ? '0 : gcnt + 1'b1;
            end else begin
               rcnt_nxt = rcnt + 1'b1;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wcnt       <= '0;
         rcnt       <= '0;
         gcnt       <= '0;
         dout_valid <= 1'b0;
         dout_sog   <= 1'b0;
         dout_eof   <= 1'b0;
         err_ovf    <= 1'b0;
         dout_r     <= '0;
         dout_i     <= '0;
      end else begin
         wcnt       <= wcnt_nxt;
         rcnt       <= rcnt_nxt;
         gcnt       <= gcnt_nxt;
         dout_valid <= valid_nxt;
         dout_sog   <= sog_nxt;
         dout_eof   <= eof_nxt;
         err_ovf    <= ovf_nxt;
         dout_r     <= r_nxt;
         dout_i     <= i_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         sub_buf_r[wcnt] <= din_sub_r;
         sub_buf_i[wcnt] <= din_sub_i;
      end
   end

endmodule

// File: doc/bf_pair_merge.md
Name: bf_pair_merge

Overview:
- Counterpart of the stage-1 split butterfly. That stage turns one 16-lane stream into parallel sum (A+B) and difference (A−B) streams; this block turns those two streams back into one 16-lane stream.
- For each group of BLK accepted beats it forwards the sum lanes at once and buffers the difference lanes. It then plays the difference lanes out immediately after the sums, so downstream sees all sums of a group followed by all differences.
- It sits between a stage-N butterfly and the next stage's delay line.

Parameters:
- DATA_WIDTH, 12, signed width of every real/imag lane, in and out.
- LANES, 16, samples per beat.
- BLK, 2, beats per half-group; also the depth of the difference buffer (≥1).
- GROUPS, 16, groups per frame; used for dout_eof.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- din_valid  in  1  qualifies all din_* lanes this cycle.
- din_add_r  in  DATA_WIDTH x LANES  sum stream, real.
- din_add_i  in  DATA_WIDTH x LANES  sum stream, imag.
- din_sub_r  in  DATA_WIDTH x LANES  difference stream, real.
- din_sub_i  in  DATA_WIDTH x LANES  difference stream, imag.
- dout_valid  out  1  output beat valid.
- dout_r  out  DATA_WIDTH x LANES  merged stream, real.
- dout_i  out  DATA_WIDTH x LANES  merged stream, imag.
- dout_sog  out  1  first beat of a group (first sum beat).
- dout_eof  out  1  last beat of the last group of a frame.
- err_ovf  out  1  sticky: input arrived while draining.

Behaviour:
- Reset (async, rstn=0): state=COLLECT, wcnt=0, rcnt=0, gcnt=0. Outputs dout_valid=0, dout_sog=0, dout_eof=0, err_ovf=0, dout_r/dout_i all 0. Buffer contents need not be reset.
- All outputs are registered. Lane values are passed through unchanged: no rounding, no width change.
- State COLLECT:
  - Each clock edge with din_valid=1: dout_r/i<=din_add_r/i, dout_valid<=1, dout_sog<=(wcnt==0), buf[wcnt]<=din_sub_r/i, wcnt++.
  - Beats need not be consecutive. A din_valid gap leaves wcnt unchanged and drives dout_valid<=0.
  - On the edge accepting beat wcnt==BLK-1: wcnt<=0, rcnt<=0, state<=DRAIN.
  - Latency: sum beat appears 1 cycle after acceptance.
- State DRAIN:
  - Exactly BLK consecutive edges. Each edge: dout_r/i<=buf[rcnt], dout_valid<=1, dout_sog<=0, rcnt++.
  - At rcnt==BLK-1: state<=COLLECT and gcnt<=(gcnt==GROUPS-1)?0:gcnt+1.
  - dout_eof<=1 on that edge iff gcnt==GROUPS-1; otherwise dout_eof=0.
  - Result: the last sum beat of a group is followed with zero gap by BLK difference beats.
- Overflow: din_valid=1 on any DRAIN edge sets err_ovf<=1, which holds until reset. That beat is discarded: it is neither forwarded nor buffered, and wcnt is not advanced. Drain continues unaffected.
- Simultaneous events: on the edge returning DRAIN→COLLECT, a din_valid=1 still counts as a DRAIN edge and is an overflow. The first legal new beat is the following edge.
- Reset mid-group or mid-drain: all partial state is discarded. The first beat after reset release is treated as beat 0 of group 0.
- Upstream contract: the producer never asserts din_valid during the BLK cycles following each BLK-th beat. The stage-1 butterfly satisfies this naturally.
- Throughput: at most BLK input beats per 2·BLK cycles; outputs 2·BLK beats per group.

Test Plan (defaults unless noted):
- Basic group: add lanes = 100+k / sub lanes = −100−k on beat 0; add 200+k / sub −200−k on beat 1, back-to-back from cycle 0.
  -> dout_valid high at cycles 1..4.
  -> dout_r lane k = 100+k, 200+k, −100−k, −200−k.
  -> dout_sog=1 at cycle 1 only.
- Gapped input: beat 0 at cycle 0, idle at cycles 1–2, beat 1 at cycle 3.
  -> outputs at cycles 1, 4, 5, 6; dout_valid=0 at cycles 2–3.
  -> difference beats appear at cycles 5–6; err_ovf=0.
- Overflow: valid beats at cycles 0, 1, 2.
  -> err_ovf=1 from cycle 3 and stays high.
  -> output sequence is identical to the basic group; the cycle-2 beat never appears.
- Frame end: GROUPS=2, feed 2 groups, each with 2 idle cycles after it.
  -> dout_eof=1 only on the 4th difference-phase beat overall (last beat of group 1).
  -> gcnt wraps; a 3rd group gives dout_eof=0.
- Reset mid-drain: assert rstn=0 at cycle 3 of the basic group, release, then feed a fresh group.
  -> all outputs are 0 during reset.
  -> the fresh group reproduces the basic-group pattern with sog on its first beat, and no stale difference beats appear.
- Extremes: lanes at +2047 / −2048, with BLK=1 and BLK=4.
  -> values pass through bit-exact.
  -> output length is 2·BLK contiguous beats per group.
